alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Single-issue ALU execution unit with valid/ready handshakes.
//               Arithmetic/logic ops finish in one cycle; shifts walk one bit
//               per cycle through the result register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [3:0]        alu_operation_i,
   input  logic [XLEN-1:0]   operand_a_i,
   input  logic [XLEN-1:0]   operand_b_i,
   input  logic [4:0]        rd_tag_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [XLEN-1:0]   result_o,
   output logic              zero_o,
   output logic [4:0]        rd_tag_o,
   output logic              busy_o
);

   localparam int SW = $clog2(XLEN);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   localparam logic [1:0] SH_LL = 2'd0;
   localparam logic [1:0] SH_RL = 2'd1;
   localparam logic [1:0] SH_RA = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic [4:0]      tag_q, tag_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [1:0]      shk_q, shk_d;

   logic [XLEN-1:0] alu_res;
   logic            is_shift;
   logic [1:0]      shk_new;
   logic [SW-1:0]   shamt;
   logic            accept;

   assign shamt  = operand_b_i[SW-1:0];
   assign accept = in_valid_i & in_ready_o;

   // Decode the operation and compute the single-cycle ALU result.
   always_comb begin
      alu_res  = operand_a_i + operand_b_i;
      is_shift = 1'b0;
      shk_new  = SH_LL;
      case (alu_operation_i)
         OP_SUB:  alu_res = operand_a_i - operand_b_i;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(operand_a_i) < $signed(operand_b_i))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (operand_a_i < operand_b_i)};
         OP_XOR:  alu_res = operand_a_i ^ operand_b_i;
         OP_OR:   alu_res = operand_a_i | operand_b_i;
         OP_AND:  alu_res = operand_a_i & operand_b_i;
         OP_SLL:  begin is_shift = 1'b1; shk_new = SH_LL; end
         OP_SRL:  begin is_shift = 1'b1; shk_new = SH_RL; end
         OP_SRA:  begin is_shift = 1'b1; shk_new = SH_RA; end
         default: alu_res = operand_a_i + operand_b_i;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: a zero-length shift completes like a plain ALU op.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (is_shift && (shamt != '0)) state_d = S_SHIFT;
               else                           state_d = S_DONE;
            end else if (state_q == S_DONE && out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: if (cnt_q == SW'(1)) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake and status outputs derived from the current state.
   always_comb begin
      in_ready_o  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
      out_valid_o = (state_q == S_DONE);
      busy_o      = (state_q != S_IDLE);
   end

   // Datapath next values: load on acceptance, shift one bit per SHIFT cycle.
   always_comb begin
      result_d = result_q;
      tag_d    = tag_q;
      cnt_d    = cnt_q;
      shk_d    = shk_q;
      if (accept) begin
         tag_d = rd_tag_i;
         if (is_shift) begin
            result_d = operand_a_i;
            cnt_d    = shamt;
            shk_d    = shk_new;
         end else begin
            result_d = alu_res;
            cnt_d    = '0;
         end
      end else if (state_q == S_SHIFT) begin
         cnt_d = cnt_q - SW'(1);
         case (shk_q)
            SH_RL:   result_d = {1'b0, result_q[XLEN-1:1]};
            SH_RA:   result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
            default: result_d = {result_q[XLEN-2:0], 1'b0};
         endcase
      end
      zero_d = (result_d == '0);
   end

   // Datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         result_q <= '0;
         zero_q   <= 1'b1;
         tag_q    <= '0;
         cnt_q    <= '0;
         shk_q    <= SH_LL;
      end else begin
         result_q <= result_d;
         zero_q   <= zero_d;
         tag_q    <= tag_d;
         cnt_q    <= cnt_d;
         shk_q    <= shk_d;
      end
   end

   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign rd_tag_o = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   logic        r_clk = 1'b0;
   logic        r_rst = 1'b1;
   logic        r_in_valid = 1'b0;
   logic        r_out_ready = 1'b0;
   logic [3:0]  r_op = 4'd0;
   logic [31:0] r_a = 32'd0;
   logic [31:0] r_b = 32'd0;
   logic [4:0]  r_tag = 5'd0;
   logic        w_in_ready, w_out_valid, w_zero, w_busy;
   logic [31:0] w_result;
   logic [4:0]  w_tag;

   int n_cmp = 0;
   int n_err = 0;

   alu_exec_unit #(.XLEN(32)) u_dut (
      .clk_i           (r_clk),
      .rst_i           (r_rst),
      .in_valid_i      (r_in_valid),
      .in_ready_o      (w_in_ready),
      .alu_operation_i (r_op),
      .operand_a_i     (r_a),
      .operand_b_i     (r_b),
      .rd_tag_i        (r_tag),
      .out_valid_o     (w_out_valid),
      .out_ready_i     (r_out_ready),
      .result_o        (w_result),
      .zero_o          (w_zero),
      .rd_tag_o        (w_tag),
      .busy_o          (w_busy)
   );

   always #5 r_clk = ~r_clk;

   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   // Present one op for exactly one edge; returns in the cycle after acceptance.
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
      r_op = op; r_a = a; r_b = b; r_tag = tag; r_in_valid = 1'b1;
      step();
      r_in_valid = 1'b0;
   endtask

   task automatic consume();
      r_out_ready = 1'b1;
      step();
      r_out_ready = 1'b0;
   endtask

   task automatic test_reset();
      r_rst = 1'b1;
      step();
      step();
      n_cmp++;
      if ({w_busy, w_out_valid, w_in_ready, w_zero} !== 4'b0011) begin
         n_err++;
         $display("FAIL reset_flags: busy/ov/ir/zero=%b expected 0011",
                  {w_busy, w_out_valid, w_in_ready, w_zero});
      end
      n_cmp++;
      if (w_result !== 32'd0 || w_tag !== 5'd0) begin
         n_err++;
         $display("FAIL reset_data: result=%h tag=%0d expected 0/0", w_result, w_tag);
      end
      r_rst = 1'b0;
   endtask

   task automatic test_add_overflow();
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
      n_cmp++;
      if ({w_out_valid, w_zero} !== 2'b10 || w_result !== 32'h8000_0000 || w_tag !== 5'd3) begin
         n_err++;
         $display("FAIL add_ovf: ov=%b zero=%b result=%h tag=%0d expected 1 0 80000000 3",
                  w_out_valid, w_zero, w_result, w_tag);
      end
      consume();
      n_cmp++;
      if (w_busy !== 1'b0 || w_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL consume_idle: busy=%b ready=%b expected 0 1", w_busy, w_in_ready);
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0]  ops [8] = '{OP_SUB, OP_SLT, OP_SLTU, 4'b1111, OP_SUB, OP_AND, OP_OR, OP_XOR};
      logic [31:0] as  [8] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd0,
                               32'h0000_F0F0, 32'h0000_F0F0, 32'hAAAA_5555};
      logic [31:0] bs  [8] = '{32'd5, 32'd1, 32'd1, 32'd3, 32'd1,
                               32'h0000_FF00, 32'h0000_FF00, 32'hAAAA_5555};
      logic [31:0] exp [8] = '{32'd0, 32'd1, 32'd0, 32'd5, 32'hFFFF_FFFF,
                               32'h0000_F000, 32'h0000_FFF0, 32'd0};
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], as[i], bs[i], 5'(i + 10));
         n_cmp++;
         if (w_out_valid !== 1'b1 || w_result !== exp[i] || w_zero !== (exp[i] == 32'd0)
             || w_tag !== 5'(i + 10)) begin
            n_err++;
            $display("FAIL alu_vec%0d: ov=%b result=%h zero=%b tag=%0d expected 1 %h %b %0d",
                     i, w_out_valid, w_result, w_zero, w_tag, exp[i], (exp[i] == 32'd0), i + 10);
         end
         consume();
      end
   endtask

   task automatic test_shift_sra();
      issue(OP_SRA, 32'h8000_0000, 32'hFFFF_FFE4, 5'd9);
      // Garbage on the inputs during the shift must not matter.
      r_in_valid = 1'b1; r_op = OP_ADD; r_a = 32'h1111_1111; r_b = 32'h2222_2222; r_tag = 5'd1;
      for (int i = 1; i <= 4; i++) begin
         n_cmp++;
         if ({w_busy, w_in_ready, w_out_valid} !== 3'b100) begin
            n_err++;
            $display("FAIL sra_cycle%0d: busy/ir/ov=%b expected 100",
                     i, {w_busy, w_in_ready, w_out_valid});
         end
         step();
      end
      n_cmp++;
      if ({w_busy, w_out_valid} !== 2'b11 || w_result !== 32'hF800_0000 || w_tag !== 5'd9) begin
         n_err++;
         $display("FAIL sra_done: busy/ov=%b result=%h tag=%0d expected 11 f8000000 9",
                  {w_busy, w_out_valid}, w_result, w_tag);
      end
      r_in_valid = 1'b0;
      consume();
   endtask

   task automatic test_shift_lengths();
      logic [3:0]  ops [4] = '{OP_SLL, OP_SLL, OP_SRL, OP_SRA};
      logic [31:0] as  [4] = '{32'h0000_1234, 32'h0000_0001, 32'h8000_0000, 32'h4000_0000};
      logic [31:0] bs  [4] = '{32'h0000_0020, 32'h0000_0003, 32'h0000_001F, 32'h0000_0002};
      logic [31:0] exp [4] = '{32'h0000_1234, 32'h0000_0008, 32'h0000_0001, 32'h1000_0000};
      int          lat [4] = '{0, 3, 31, 2};
      int          waited;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], as[i], bs[i], 5'd4);
         r_a = 32'hDEAD_BEEF; r_b = 32'h0;
         waited = 0;
         while (w_out_valid !== 1'b1 && waited < 60) begin
            step();
            waited++;
         end
         n_cmp++;
         if (waited !== lat[i] || w_result !== exp[i]) begin
            n_err++;
            $display("FAIL shift_vec%0d: latency=%0d result=%h expected %0d %h",
                     i, waited, w_result, lat[i], exp[i]);
         end
         consume();
      end
   endtask

   task automatic test_back_to_back();
      issue(OP_ADD, 32'd10, 32'd20, 5'd6);
      for (int i = 0; i < 3; i++) begin
         r_in_valid = ~r_in_valid; r_a = $urandom; r_b = $urandom; r_op = OP_SUB;
         step();
         n_cmp++;
         if ({w_out_valid, w_in_ready} !== 2'b10 || w_result !== 32'd30 || w_zero !== 1'b0
             || w_tag !== 5'd6) begin
            n_err++;
            $display("FAIL hold%0d: ov/ir=%b result=%h zero=%b tag=%0d expected 10 1e 0 6",
                     i, {w_out_valid, w_in_ready}, w_result, w_zero, w_tag);
         end
      end
      r_out_ready = 1'b1; r_in_valid = 1'b1;
      r_op = OP_XOR; r_a = 32'h0000_00F0; r_b = 32'h0000_00FF; r_tag = 5'd7;
      #1;
      n_cmp++;
      if (w_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_ready: in_ready=%b expected 1", w_in_ready);
      end
      step();
      r_in_valid = 1'b0;
      r_out_ready = 1'b0;
      n_cmp++;
      if (w_out_valid !== 1'b1 || w_result !== 32'h0000_000F || w_tag !== 5'd7) begin
         n_err++;
         $display("FAIL b2b_result: ov=%b result=%h tag=%0d expected 1 0000000f 7",
                  w_out_valid, w_result, w_tag);
      end
      consume();
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      issue(OP_SRL, 32'hFFFF_0000, 32'd10, 5'd12);
      step();
      r_rst = 1'b1;
      r_out_ready = 1'b1;
      step();
      r_rst = 1'b0;
      r_out_ready = 1'b0;
      n_cmp++;
      if ({w_busy, w_out_valid, w_in_ready} !== 3'b001 || w_result !== 32'd0 || w_zero !== 1'b1) begin
         n_err++;
         $display("FAIL rst_shift: busy/ov/ir=%b result=%h zero=%b expected 001 0 1",
                  {w_busy, w_out_valid, w_in_ready}, w_result, w_zero);
      end
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (w_out_valid === 1'b1) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_err++;
         $display("FAIL rst_no_valid: out_valid cycles=%0d expected 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_alu_ops();
      test_shift_sra();
      test_shift_lengths();
      test_back_to_back();
      test_reset_mid_shift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
